// File: rtl/audio_adc_receiver.sv
// ---------------------------------------------------------------------------
// audio_adc_receiver
//
// Capture side of the codec serial audio link. AUD_BCK, AUD_LRCK and
// AUD_ADCDAT are oversampled in the iCLK domain and each I2S (or
// left-justified) frame becomes one left/right sample pair. The pair sits in
// a one-deep output register with a valid/ready handshake and a sticky
// overrun flag.
//
// Handshake: a pair moves downstream in every cycle where oValid and iReady
// are both high. oValid stays high, and oL/oR stay unchanged, until that
// happens. The one exception is a new pair arriving while oValid & ~iReady:
// it overwrites the held pair and sets oOverrun.
//
// Ports
//   iCLK        system clock (at least 8x the BCK rate)
//   iRST        synchronous active-high reset
//   AUD_BCK     codec bit clock (asynchronous)
//   AUD_LRCK    codec ADC LR clock (asynchronous), low = left, high = right
//   AUD_ADCDAT  codec ADC serial data (asynchronous), MSB first
//   iReady      downstream accepts the pair when high together with oValid
//   iClrOvr     clears oOverrun (a coincident overrun wins)
//   oL, oR      left/right samples, two's complement
//   oValid      a pair is available
//   oOverrun    sticky: an unaccepted pair was overwritten
//   oFrameCnt   completed pairs since reset, wraps 65535 -> 0
// ---------------------------------------------------------------------------
module audio_adc_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int I2S_DELAY  = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  AUD_BCK,
    input  logic                  AUD_LRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  iReady,
    input  logic                  iClrOvr,
    output logic [DATA_WIDTH-1:0] oL,
    output logic [DATA_WIDTH-1:0] oR,
    output logic                  oValid,
    output logic                  oOverrun,
    output logic [15:0]           oFrameCnt
);

    localparam logic [5:0] DLY = 6'(I2S_DELAY);
    localparam logic [5:0] WID = 6'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONLY = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Synchronizers (s1 -> s2) plus one history stage for edge detection.
    logic bck_s1, bck_s2, bck_hist;
    logic lr_s1, lr_s2, lr_hist;
    logic dat_s1, dat_s2;

    logic                  armed;
    logic                  have_l;
    logic [5:0]            bitcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold_l;

    logic                  bck_rise;
    logic                  lr_edge;
    logic                  load_pair;
    logic [5:0]            word_idx;
    logic                  in_word;
    logic [DATA_WIDTH-1:0] bit_mask;

    assign bck_rise  = bck_s2 & ~bck_hist;
    assign lr_edge   = lr_s2 ^ lr_hist;
    // lr_hist is the channel that just ended: high means the right word.
    assign load_pair = lr_edge & lr_hist & have_l;

    assign word_idx  = bitcnt - DLY;
    assign in_word   = (bitcnt >= DLY) && (word_idx < WID);

    // One-hot select of the shreg bit that the current BCK rise writes.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (in_word && (word_idx == 6'(DATA_WIDTH - 1 - i))) begin
                bit_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bck_s1    <= 1'b0;
            bck_s2    <= 1'b0;
            bck_hist  <= 1'b0;
            lr_s1     <= 1'b0;
            lr_s2     <= 1'b0;
            lr_hist   <= 1'b0;
            dat_s1    <= 1'b0;
            dat_s2    <= 1'b0;
            armed     <= 1'b0;
            have_l    <= 1'b0;
            bitcnt    <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            oL        <= '0;
            oR        <= '0;
            oValid    <= 1'b0;
            oOverrun  <= 1'b0;
            oFrameCnt <= '0;
        end else begin
            bck_s1   <= AUD_BCK;
            bck_s2   <= bck_s1;
            bck_hist <= bck_s2;
            lr_s1    <= AUD_LRCK;
            lr_s2    <= lr_s1;
            lr_hist  <= lr_s2;
            dat_s1   <= AUD_ADCDAT;
            dat_s2   <= dat_s1;

            if (lr_edge) begin
                // Word boundary: commit the finished word from the old shreg.
                if (!lr_hist) begin
                    if (armed) begin
                        hold_l <= shreg;
                        have_l <= 1'b1;
                    end
                end else if (have_l) begin
                    have_l <= 1'b0;
                end
                // Anything captured before the first boundary is partial.
                armed <= 1'b1;
                // A BCK rise in the same cycle is bit 0 of the new word.
                if (bck_rise) begin
                    bitcnt <= 6'd1;
                    shreg  <= (I2S_DELAY == 0 && dat_s2) ? MSB_ONLY : '0;
                end else begin
                    bitcnt <= 6'd0;
                    shreg  <= '0;
                end
            end else if (bck_rise) begin
                if (bitcnt != 6'd63) begin
                    bitcnt <= bitcnt + 6'd1;
                end
                shreg <= (shreg & ~bit_mask) | (bit_mask & {DATA_WIDTH{dat_s2}});
            end

            if (load_pair) begin
                oL        <= hold_l;
                oR        <= shreg;
                oValid    <= 1'b1;
                oFrameCnt <= oFrameCnt + 16'd1;
            end else if (oValid && iReady) begin
                oValid <= 1'b0;
            end

            if (load_pair && oValid && !iReady) begin
                oOverrun <= 1'b1;
            end else if (iClrOvr) begin
                oOverrun <= 1'b0;
            end
        end
    end

endmodule
